// File: rtl/seg7_scan_display_pkg.sv
// seg7_pkg: shared seven-segment patterns and width helper for the lab display blocks.
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: value/control inputs and display pin outputs of the scan driver.
interface seg7_scan_display_if #(parameter int DIGITS = 8);
  logic [4*DIGITS-1:0] data_i;
  logic [DIGITS-1:0] dp_i;
  logic load_i;
  logic blank_lz_i;
  logic pending_o;
  logic frame_o;
  logic [6:0] hex_o;
  logic dp_o;
  logic [DIGITS-1:0] hex_on_o;
  modport master (
    output data_i, dp_i, load_i, blank_lz_i,
    input pending_o, frame_o, hex_o, dp_o, hex_on_o
  );
  modport slave (
    input data_i, dp_i, load_i, blank_lz_i,
    output pending_o, frame_o, hex_o, dp_o, hex_on_o
  );
endinterface

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_PAT[i_nib];
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed digit scanner with frame-synchronous value load,
// leading-zero blanking and per-digit decimal points.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DIV = 100000
) (
  input logic clk,
  input logic rst,
  seg7_scan_display_if.slave bus
);
  localparam int IW = idx_w(DIGITS);
  localparam int PW = idx_w(DIV);
  localparam int N = 2 ** IW;
  logic [PW-1:0] r_pcnt;
  logic [IW-1:0] r_idx;
  logic [4*DIGITS-1:0] r_disp, r_pend;
  logic r_pend_v, r_frame, r_dp;
  logic [6:0] r_hex;
  logic [DIGITS-1:0] r_on;
  logic w_tick, w_wrap, w_blank;
  logic [4*N-1:0] w_disp;
  logic [N-1:0] w_dp, w_lz;
  logic [3:0] w_nib;
  logic [6:0] w_seg;
  assign w_tick = r_pcnt == PW'(DIV - 1);
  assign w_wrap = w_tick && r_idx == IW'(DIGITS - 1);
  // Vectors padded to a power of two so indexing by r_idx is always in range.
  always_comb begin
    logic z;
    w_disp = '0;
    w_disp[4*DIGITS-1:0] = r_disp;
    w_dp = '0;
    w_dp[DIGITS-1:0] = bus.dp_i;
    w_lz = '0;
    z = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      z = z && r_disp[4*k +: 4] == 4'd0;
      w_lz[k] = z;
    end
    w_nib = w_disp[{r_idx, 2'b00} +: 4];
    w_blank = bus.blank_lz_i && r_idx != '0 && w_lz[r_idx];
  end
  hex_to_seg7 u_dec (.i_nib(w_nib), .o_seg(w_seg));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
      r_idx <= '0;
      r_disp <= '0;
      r_pend <= '0;
      r_pend_v <= 1'b0;
      r_frame <= 1'b0;
      r_on <= '1;
      r_hex <= SEG_BLANK;
      r_dp <= 1'b1;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
      if (w_tick) r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      if (w_wrap) begin
        r_pend_v <= 1'b0;
        if (bus.load_i) r_disp <= bus.data_i;
        else if (r_pend_v) r_disp <= r_pend;
      end else if (bus.load_i) begin
        r_pend <= bus.data_i;
        r_pend_v <= 1'b1;
      end
      r_frame <= w_wrap;
      r_on <= w_blank ? '1 : ~(DIGITS'(1) << r_idx);
      r_hex <= w_blank ? SEG_BLANK : w_seg;
      r_dp <= w_blank | ~w_dp[r_idx];
    end
  end
  assign bus.pending_o = r_pend_v;
  assign bus.frame_o = r_frame;
  assign bus.hex_on_o = r_on;
  assign bus.hex_o = r_hex;
  assign bus.dp_o = r_dp;
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed frame-by-frame scoreboard check of the scan display driver.
module tb_seg7_scan_display;
  typedef struct packed {
    logic [3:0] on;
    logic [6:0] hex;
    logic dp;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] nib;
  logic [6:0] seg;
  logic pend_exp;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  logic [6:0] tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  always #5 clk = ~clk;
  seg7_scan_display_if #(.DIGITS(4)) bus ();
  seg7_scan_display_if #(.DIGITS(1)) bus1 ();
  seg7_scan_display #(.DIGITS(4), .DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  seg7_scan_display #(.DIGITS(1), .DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  hex_to_seg7 dec (.i_nib(nib), .o_seg(seg));
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  task automatic push_frame(input logic [15:0] v, input logic b, input logic [3:0] dpm);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      logic [3:0] n;
      n = v[4*k +: 4];
      if (b && k != 0 && (v >> (4 * k)) == 16'd0) e = {4'hF, 7'h7F, 1'b1};
      else e = {~(4'b0001 << k), tbl[n], ~dpm[k]};
      q.push_back(e);
    end
  endtask
  task automatic run_frame(input int a1, input logic [15:0] v1, input int a2, input logic [15:0] v2);
    for (int d = 0; d < 4; d++) begin
      exp_t e;
      e = q.pop_front();
      for (int s = 0; s < 4; s++) begin
        int c;
        c = 4 * d + s;
        bus.load_i = (c == a1) || (c == a2);
        bus.data_i = (c == a2) ? v2 : v1;
        if (bus.load_i && c != 15) pend_exp = 1'b1;
        @(negedge clk);
        bus.load_i = 1'b0;
        if (c == 15) pend_exp = 1'b0;
        chk("anode", bus.hex_on_o, e.on);
        chk("seg", bus.hex_o, e.hex);
        chk("dp", bus.dp_o, e.dp);
        chk("frame", bus.frame_o, c == 15);
        chk("pending", bus.pending_o, pend_exp);
      end
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_anode"}, bus.hex_on_o, 4'hF);
    chk({tag, "_seg"}, bus.hex_o, 7'h7F);
    chk({tag, "_dp"}, bus.dp_o, 1'b1);
    chk({tag, "_frame"}, bus.frame_o, 1'b0);
    chk({tag, "_pending"}, bus.pending_o, 1'b0);
  endtask
  initial begin
    bus.data_i = 16'h1234;
    bus.load_i = 1'b1;
    bus.dp_i = 4'b0000;
    bus.blank_lz_i = 1'b0;
    bus1.data_i = 4'h0;
    bus1.load_i = 1'b0;
    bus1.dp_i = 1'b0;
    bus1.blank_lz_i = 1'b0;
    nib = 4'h0;
    pend_exp = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    chk("rst1_anode", bus1.hex_on_o, 1'b1);
    chk("rst1_frame", bus1.frame_o, 1'b0);
    rst = 1'b0;
    bus.load_i = 1'b0;
    push_frame(16'h0000, 1'b0, 4'b0000);
    run_frame(2, 16'h1234, -1, 16'h0);
    push_frame(16'h1234, 1'b0, 4'b0000);
    run_frame(4, 16'hABCD, 6, 16'h5678);
    push_frame(16'h5678, 1'b0, 4'b0000);
    run_frame(15, 16'hFFFF, -1, 16'h0);
    bus.dp_i = 4'b0101;
    push_frame(16'hFFFF, 1'b0, 4'b0101);
    run_frame(3, 16'h0030, -1, 16'h0);
    bus.dp_i = 4'b0000;
    bus.blank_lz_i = 1'b1;
    push_frame(16'h0030, 1'b1, 4'b0000);
    run_frame(0, 16'h0000, -1, 16'h0);
    push_frame(16'h0000, 1'b1, 4'b0000);
    run_frame(-1, 16'h0, -1, 16'h0);
    bus.blank_lz_i = 1'b0;
    bus.load_i = 1'b1;
    bus.data_i = 16'h7777;
    @(negedge clk);
    bus.load_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_pending", bus.pending_o, 1'b1);
    chk("mid_anode", bus.hex_on_o, 4'b1011);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0;
    pend_exp = 1'b0;
    push_frame(16'h0000, 1'b0, 4'b0000);
    run_frame(-1, 16'h0, -1, 16'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("d1_anode", bus1.hex_on_o, 1'b0);
      chk("d1_frame", bus1.frame_o, 1'b1);
    end
    chk("d1_seg0", bus1.hex_o, 7'b1000000);
    bus1.load_i = 1'b1;
    bus1.data_i = 4'h7;
    @(negedge clk);
    bus1.load_i = 1'b0;
    @(negedge clk);
    chk("d1_seg7", bus1.hex_o, 7'b1111000);
    chk("d1_pending", bus1.pending_o, 1'b0);
    for (int i = 0; i < 16; i++) begin
      nib = 4'(i);
      #1;
      chk($sformatf("dec%0h", i), seg, tbl[i]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
